// File: rtl/uart_tx_arbiter_if.sv
// Requester/transmitter bundle for uart_tx_arbiter.
// req_lock exists only when UART_ARB_LOCK_EN is defined.
interface uart_tx_arbiter_if #(
  parameter int NUM_REQ = 4
);
  localparam int IW = $clog2(NUM_REQ);

  logic [NUM_REQ-1:0]   req_valid;
  logic [8*NUM_REQ-1:0] req_data;
  logic [NUM_REQ-1:0]   req_ready;
`ifdef UART_ARB_LOCK_EN
  logic [NUM_REQ-1:0]   req_lock;
`endif
  logic                 tx_en;
  logic [7:0]           tx_data;
  logic                 tx_busy;
  logic [IW-1:0]        grant_id;
  logic                 frame_done;
  logic                 timeout_err;
  logic                 arb_busy;

  modport master (
`ifdef UART_ARB_LOCK_EN
    input  req_lock,
`endif
    input  req_valid,
    input  req_data,
    input  tx_busy,
    output req_ready,
    output tx_en,
    output tx_data,
    output grant_id,
    output frame_done,
    output timeout_err,
    output arb_busy
  );

  modport slave (
`ifdef UART_ARB_LOCK_EN
    output req_lock,
`endif
    output req_valid,
    output req_data,
    output tx_busy,
    input  req_ready,
    input  tx_en,
    input  tx_data,
    input  grant_id,
    input  frame_done,
    input  timeout_err,
    input  arb_busy
  );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Round-robin share of one UART transmitter with start/frame watchdogs.
// Define UART_ARB_LOCK_EN to let a locked requester keep the grant.
module uart_tx_arbiter #(
  parameter int NUM_REQ       = 4,
  parameter int GAP_CYCLES    = 2,
  parameter int START_TIMEOUT = 8,
  parameter int FRAME_TIMEOUT = 64
) (
  input  logic clk,
  input  logic reset,
  uart_tx_arbiter_if.master bus
);

  localparam int IW = $clog2(NUM_REQ);
  localparam int M1 = (START_TIMEOUT > FRAME_TIMEOUT) ?
                      START_TIMEOUT : FRAME_TIMEOUT;
  localparam int CMAX = (M1 > GAP_CYCLES) ? M1 : GAP_CYCLES;
  localparam int CW = $clog2(CMAX + 1);

  localparam logic [CW-1:0] CNT_MAX = CW'(CMAX);
  localparam logic [CW-1:0] ST_LAST = CW'(START_TIMEOUT - 1);
  localparam logic [CW-1:0] FR_LAST = CW'(FRAME_TIMEOUT - 1);
  localparam logic [CW-1:0] GP_LAST =
    CW'((GAP_CYCLES == 0) ? 0 : GAP_CYCLES - 1);

  typedef enum logic [2:0] {
    IDLE,
    LAUNCH,
    WAIT_START,
    WAIT_DONE,
    GAP
  } state_e;

  state_e          state_q;
  logic [IW-1:0]   ptr_q;
  logic [IW-1:0]   grant_q;
  logic [7:0]      tx_data_q;
  logic [CW-1:0]   cnt_q;
  logic            tx_en_q;
  logic            frame_done_q;
  logic            timeout_q;
  logic            busy_q;

  logic [CW-1:0]   cnt_d;
  logic [IW-1:0]   rr_sel;
  logic [IW-1:0]   sel_d;
  logic [IW-1:0]   ptr_d;
  logic            any_valid;
  logic            lock_hit;

  assign cnt_d = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;
  assign any_valid = |bus.req_valid;

  // Walk from far to near so the nearest valid to ptr wins.
  always_comb begin
    logic [IW-1:0] cand;
    rr_sel = '0;
    cand   = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      cand = IW'((int'(ptr_q) + k) % NUM_REQ);
      if (bus.req_valid[cand]) rr_sel = cand;
    end
  end

`ifdef UART_ARB_LOCK_EN
  logic lock_ok_q;

  assign lock_hit = lock_ok_q &&
                    bus.req_lock[grant_q] &&
                    bus.req_valid[grant_q];

  // A watchdog abort breaks the packet lock.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      lock_ok_q <= 1'b0;
    end else if (frame_done_q) begin
      lock_ok_q <= 1'b1;
    end else if (timeout_q) begin
      lock_ok_q <= 1'b0;
    end
  end
`else
  assign lock_hit = 1'b0;
`endif

  assign sel_d = lock_hit ? grant_q : rr_sel;
  assign ptr_d = (sel_d == IW'(NUM_REQ - 1)) ?
                 '0 : sel_d + 1'b1;

  assign bus.req_ready =
    (state_q == IDLE && !reset && any_valid) ?
    (NUM_REQ'(1) << sel_d) : '0;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      ptr_q        <= '0;
      grant_q      <= '0;
      tx_data_q    <= '0;
      cnt_q        <= '0;
      tx_en_q      <= 1'b0;
      frame_done_q <= 1'b0;
      timeout_q    <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      tx_en_q      <= 1'b0;
      frame_done_q <= 1'b0;
      timeout_q    <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (any_valid) begin
            grant_q   <= sel_d;
            tx_data_q <= bus.req_data[{sel_d, 3'b000} +: 8];
            if (!lock_hit) ptr_q <= ptr_d;
            tx_en_q   <= 1'b1;
            busy_q    <= 1'b1;
            state_q   <= LAUNCH;
          end
        end
        LAUNCH: begin
          cnt_q   <= '0;
          state_q <= WAIT_START;
        end
        WAIT_START: begin
          if (bus.tx_busy) begin
            cnt_q   <= '0;
            state_q <= WAIT_DONE;
          end else if (cnt_q >= ST_LAST) begin
            cnt_q     <= '0;
            timeout_q <= 1'b1;
            state_q   <= GAP;
          end else begin
            cnt_q <= cnt_d;
          end
        end
        WAIT_DONE: begin
          if (!bus.tx_busy) begin
            cnt_q        <= '0;
            frame_done_q <= 1'b1;
            state_q      <= GAP;
          end else if (cnt_q >= FR_LAST) begin
            cnt_q     <= '0;
            timeout_q <= 1'b1;
            state_q   <= GAP;
          end else begin
            cnt_q <= cnt_d;
          end
        end
        GAP: begin
          if (cnt_q >= GP_LAST) begin
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end else begin
            cnt_q <= cnt_d;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.tx_en       = tx_en_q;
  assign bus.tx_data     = tx_data_q;
  assign bus.grant_id    = grant_q;
  assign bus.frame_done  = frame_done_q;
  assign bus.timeout_err = timeout_q;
  assign bus.arb_busy    = busy_q;

endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
- Shares one UART transmitter (enable / 8-bit data / busy interface) between NUM_REQ byte requesters.
- Fair round-robin selection; sequences each frame: launch -> wait busy rise -> wait busy fall -> inter-frame guard.
- Sits between the command/telemetry sources and the UART transmitter.
- Watchdogs detect a transmitter that never starts or never finishes.

Parameters:
- NUM_REQ, 4, number of requesters (2..8)
- GAP_CYCLES, 2, idle clocks forced between frames (0..255)
- START_TIMEOUT, 8, max clocks from tx_en to tx_busy high
- FRAME_TIMEOUT, 64, max clocks tx_busy may stay high per frame

Ports:
- clk  in  1  clock
- reset  in  1  reset, asynchronous, active-high
- req_valid  in  NUM_REQ  per-requester byte pending
- req_data  in  8*NUM_REQ  requester i byte at [8i+7:8i]
- req_ready  out  NUM_REQ  one-hot 1-cycle accept pulse; byte consumed
- tx_en  out  1  1-cycle launch strobe to transmitter
- tx_data  out  8  byte to transmitter, held stable from launch until frame end
- tx_busy  in  1  transmitter frame in progress
- grant_id  out  $clog2(NUM_REQ)  index of current/last granted requester
- frame_done  out  1  1-cycle pulse on normal frame completion
- timeout_err  out  1  1-cycle pulse on watchdog abort
- arb_busy  out  1  high in any state other than IDLE

Behaviour:
- Reset values: req_ready=0, tx_en=0, tx_data=0, grant_id=0, frame_done=0, timeout_err=0, arb_busy=0, state=IDLE, round-robin pointer=0, counters=0.
- Reset mid-frame aborts immediately; the accepted byte is lost and no pulses are issued.
- IDLE state:
  - If any req_valid is set, pick the first set bit searching from ptr, ptr+1, ... with wrap modulo NUM_REQ.
  - Same cycle: req_ready[i]=1, latch req_data[i] into tx_data, grant_id=i, ptr<=i+1 (wrap), go to LAUNCH.
  - Requester holds valid/data until it sees ready; a valid bit dropped before grant is simply not served.
- LAUNCH state: tx_en=1 for exactly one cycle; clear the watchdog counter; go to WAIT_START.
- WAIT_START state:
  - tx_busy=1 -> WAIT_DONE, counter cleared.
  - Otherwise count; at START_TIMEOUT cycles, pulse timeout_err and go to GAP.
- WAIT_DONE state:
  - tx_busy=0 -> pulse frame_done and go to GAP.
  - Otherwise count; at FRAME_TIMEOUT cycles, pulse timeout_err and go to GAP.
- GAP state: stay GAP_CYCLES clocks, then IDLE. With GAP_CYCLES=0, pass through in one cycle.
- Minimum latency from req_valid in IDLE to tx_en: 1 cycle (ready in cycle 0, tx_en in cycle 1).
- tx_busy already high at LAUNCH+1 is accepted immediately, i.e. a one-cycle busy rise.
- New requests arriving while arb_busy=1 wait; they are evaluated only in IDLE.
- Only one req_ready bit is ever high; never during a frame.
- Pointer arithmetic: ptr width $clog2(NUM_REQ); i+1==NUM_REQ wraps to 0.
- Counters sized to hold max(START_TIMEOUT, FRAME_TIMEOUT, GAP_CYCLES); saturate, never wrap.

Optional Feature:
- Macro: UART_ARB_LOCK_EN
- Defined:
  - Adds input req_lock [NUM_REQ].
  - If req_lock[grant_id]=1 when GAP ends and req_valid[grant_id]=1, the same requester is granted again, bypassing round-robin; ptr is not advanced. This keeps multi-byte packets contiguous.
  - A lock is ignored after a timeout_err; normal round-robin applies.
- Undefined: no req_lock port; pure round-robin.

Test Plan:
- Single request: req_valid=4'b0100, data 0xA5, transmitter model busy high 3..12 cycles after tx_en -> req_ready[2] 1 cycle, tx_en next cycle, tx_data=0xA5 held, frame_done once, grant_id=2, then GAP_CYCLES=2 idle.
- All four valid continuously, ptr=0 -> grant order 0,1,2,3,0; each grant separated by one full frame plus the gap.
- Transmitter never raises busy -> timeout_err exactly 8 cycles after leaving LAUNCH, no frame_done, next requester served.
- Busy stuck high -> timeout_err at 64 cycles in WAIT_DONE; arbiter returns to IDLE after the gap.
- Reset asserted in WAIT_DONE -> all outputs 0 asynchronously, ptr=0; after release, req 3 served first if it is the only request.
- (UART_ARB_LOCK_EN) req 1 locked with 3 bytes, req 2 valid -> bytes 1,1,1 contiguous, then 2.
